// File: rtl/reorder_buffer_pkg.sv
// Shared ROB configuration: geometry, entry type codes and the per-entry payload layout.
// Used by the ROB itself and by the decoder, RS and LSB that talk to it.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_BIT = 3;
  localparam int ROB_TYPE_BIT = 2;
  localparam int ROB_DEPTH    = 1 << ROB_SIZE_BIT;
  localparam int DATA_W       = 32;
  localparam int REG_W        = 5;

  typedef logic [ROB_SIZE_BIT-1:0] rob_id_t;

  typedef enum logic [ROB_TYPE_BIT-1:0] {
    ROB_REG  = 2'd0,
    ROB_REGI = 2'd1,
    ROB_BR   = 2'd2,
    ROB_ST   = 2'd3
  } rob_type_e;

  typedef struct packed {
    rob_type_e          typ;
    logic [REG_W-1:0]   rd;
    logic [DATA_W-1:0]  value;
    logic [DATA_W-1:0]  addr;
  } rob_entry_t;

  function automatic rob_id_t rob_next(input rob_id_t id);
    return id + rob_id_t'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Decoder issue, operand query, CDB, commit and flush signals seen by the reorder buffer.
// The slave side is the ROB; the master side is the rest of the core.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic              rob_input;
  logic              rob_fi;
  logic [DATA_W-1:0] rob_value;
  logic [DATA_W-1:0] rob_addr;
  rob_type_e         rob_type;
  logic [REG_W-1:0]  rob_reg_id;
  logic              rob_full;
  rob_id_t           rob_vacant_id;

  logic              rob_clear;
  logic [DATA_W-1:0] clear_pc;

  rob_id_t           rob_qry1_id;
  logic              rob_qry1_fi;
  logic [DATA_W-1:0] rob_qry1_value;
  rob_id_t           rob_qry2_id;
  logic              rob_qry2_fi;
  logic [DATA_W-1:0] rob_qry2_value;

  logic              cdb_valid;
  rob_id_t           cdb_rob_id;
  logic [DATA_W-1:0] cdb_value;

  logic              commit_valid;
  logic [REG_W-1:0]  commit_reg_id;
  logic [DATA_W-1:0] commit_value;
  rob_id_t           commit_rob_id;
  logic              st_commit;
  rob_id_t           st_commit_id;

  modport slave (
    input  rob_input, rob_fi, rob_value, rob_addr, rob_type, rob_reg_id,
    input  rob_qry1_id, rob_qry2_id,
    input  cdb_valid, cdb_rob_id, cdb_value,
    output rob_full, rob_vacant_id, rob_clear, clear_pc,
    output rob_qry1_fi, rob_qry1_value, rob_qry2_fi, rob_qry2_value,
    output commit_valid, commit_reg_id, commit_value, commit_rob_id,
    output st_commit, st_commit_id
  );

  modport master (
    output rob_input, rob_fi, rob_value, rob_addr, rob_type, rob_reg_id,
    output rob_qry1_id, rob_qry2_id,
    output cdb_valid, cdb_rob_id, cdb_value,
    input  rob_full, rob_vacant_id, rob_clear, clear_pc,
    input  rob_qry1_fi, rob_qry1_value, rob_qry2_fi, rob_qry2_value,
    input  commit_valid, commit_reg_id, commit_value, commit_rob_id,
    input  st_commit, st_commit_id
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates on issue, captures CDB results, retires in order
// and raises a one-cycle flush with the restart PC on a branch mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  rob
);

  localparam int CNT_W = ROB_SIZE_BIT + 1;
  localparam int OCC_W = ROB_SIZE_BIT + 2;

  logic [ROB_DEPTH-1:0] busy_q;
  logic [ROB_DEPTH-1:0] ready_q;
  rob_entry_t           ent_q [ROB_DEPTH];
  rob_id_t              head_q;
  rob_id_t              tail_q;
  logic [CNT_W-1:0]     count_q;

  logic                 clear_p1;
  logic [DATA_W-1:0]    clear_pc_p1;
  logic                 commit_vld_p1;
  logic [REG_W-1:0]     commit_rd_p1;
  logic [DATA_W-1:0]    commit_val_p1;
  rob_id_t              commit_id_p1;
  logic                 st_vld_p1;
  rob_id_t              st_id_p1;

  logic                 active;
  logic                 alloc_en;
  logic                 cdb_hit;
  logic                 commit_en;
  logic                 mispredict;
  rob_entry_t           head_ent;
  rob_entry_t           alloc_ent;
  logic [CNT_W-1:0]     count_nxt;
  logic [OCC_W-1:0]     occupancy;

  function automatic logic [DATA_W:0] rob_query(
    input rob_id_t           id,
    input logic              fwd_valid,
    input rob_id_t           fwd_id,
    input logic [DATA_W-1:0] fwd_value,
    input logic              ent_busy,
    input logic              ent_ready,
    input logic [DATA_W-1:0] ent_value
  );
    if (fwd_valid && (fwd_id == id)) return {1'b1, fwd_value};
    if (ent_busy && ent_ready)       return {1'b1, ent_value};
    return '0;
  endfunction

  // The decoder sampled full/vacant a cycle before its rob_input arrives, so the
  // in-flight issue is counted here; a same-cycle commit is deliberately not credited.
  assign occupancy         = {1'b0, count_q} + OCC_W'(rob.rob_input);
  assign rob.rob_full      = occupancy >= OCC_W'(ROB_DEPTH);
  assign rob.rob_vacant_id = tail_q + rob_id_t'(rob.rob_input);

  assign {rob.rob_qry1_fi, rob.rob_qry1_value} = rob_query(
    rob.rob_qry1_id, rob.cdb_valid, rob.cdb_rob_id, rob.cdb_value,
    busy_q[rob.rob_qry1_id], ready_q[rob.rob_qry1_id], ent_q[rob.rob_qry1_id].value);
  assign {rob.rob_qry2_fi, rob.rob_qry2_value} = rob_query(
    rob.rob_qry2_id, rob.cdb_valid, rob.cdb_rob_id, rob.cdb_value,
    busy_q[rob.rob_qry2_id], ready_q[rob.rob_qry2_id], ent_q[rob.rob_qry2_id].value);

  assign active     = rdy_in & ~clear_p1;
  assign alloc_en   = active & rob.rob_input;
  assign cdb_hit    = active & rob.cdb_valid & busy_q[rob.cdb_rob_id];
  assign head_ent   = ent_q[head_q];
  assign commit_en  = active & busy_q[head_q] & ready_q[head_q];
  assign mispredict = head_ent.value[0] != head_ent.rd[0];
  assign count_nxt  = count_q + CNT_W'(alloc_en) - CNT_W'(commit_en);

  assign alloc_ent = '{typ:   rob.rob_type,
                       rd:    rob.rob_reg_id,
                       value: rob.rob_value,
                       addr:  rob.rob_addr};

  // p0 -> p1: bookkeeping update and registered commit/flush decisions
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q        <= '0;
      ready_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      clear_p1      <= 1'b0;
      clear_pc_p1   <= '0;
      commit_vld_p1 <= 1'b0;
      commit_rd_p1  <= '0;
      commit_val_p1 <= '0;
      commit_id_p1  <= '0;
      st_vld_p1     <= 1'b0;
      st_id_p1      <= '0;
    end else if (clear_p1) begin
      busy_q        <= '0;
      ready_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      clear_p1      <= 1'b0;
      commit_vld_p1 <= 1'b0;
      st_vld_p1     <= 1'b0;
    end else begin
      commit_vld_p1 <= 1'b0;
      st_vld_p1     <= 1'b0;
      if (cdb_hit) ready_q[rob.cdb_rob_id] <= 1'b1;
      if (alloc_en) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= rob.rob_fi;
        tail_q          <= rob_next(tail_q);
      end
      if (commit_en) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= rob_next(head_q);
        case (head_ent.typ)
          ROB_REG, ROB_REGI: begin
            commit_vld_p1 <= 1'b1;
            commit_rd_p1  <= head_ent.rd;
            commit_val_p1 <= head_ent.value;
            commit_id_p1  <= head_q;
          end
          ROB_ST: begin
            st_vld_p1 <= 1'b1;
            st_id_p1  <= head_q;
          end
          ROB_BR: begin
            if (mispredict) begin
              clear_p1    <= 1'b1;
              clear_pc_p1 <= head_ent.addr;
            end
          end
          default: ;
        endcase
      end
      count_q <= count_nxt;
    end
  end

  // Entry payload carries no reset; busy/ready alone decide whether it is meaningful.
  always_ff @(posedge clk_in) begin
    if (cdb_hit)  ent_q[rob.cdb_rob_id].value <= rob.cdb_value;
    if (alloc_en) ent_q[tail_q]               <= alloc_ent;
  end

  assign rob.rob_clear     = clear_p1;
  assign rob.clear_pc      = clear_pc_p1;
  assign rob.commit_valid  = commit_vld_p1;
  assign rob.commit_reg_id = commit_rd_p1;
  assign rob.commit_value  = commit_val_p1;
  assign rob.commit_rob_id = commit_id_p1;
  assign rob.st_commit     = st_vld_p1;
  assign rob.st_commit_id  = st_id_p1;

endmodule
